// File: rtl/max_pool_packer.sv
// Streaming 2x2 max-pool over NK raster-order feature maps; four pooled values
// per kernel are packed into one word for the fully-connected stage.
module max_pool_packer #(
  parameter int NK    = 2,
  parameter int MAP_W = 8,
  parameter int MAP_H = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic [NK-1:0][7:0]      conv_in,
  output logic                    out_valid,
  output logic [NK-1:0][3:0][7:0] pooled_out,
  output logic                    frame_done,
  output logic                    busy,
  output logic                    dbg_state
);

  localparam int CW  = (MAP_W > 2) ? $clog2(MAP_W) : 1;
  localparam int RW  = (MAP_H > 2) ? $clog2(MAP_H) : 1;
  localparam int LBW = MAP_W / 2;
  localparam int LIW = (LBW > 1) ? $clog2(LBW) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(MAP_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(MAP_H - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e                    state_q, state_d;
  logic [CW-1:0]             col_q, col_d;
  logic [RW-1:0]             row_q, row_d;
  logic [1:0]                lane_q, lane_d;
  logic [NK-1:0][7:0]        hold_q, hold_d;
  logic [NK-1:0][LBW-1:0][7:0] lb_q, lb_d;
  logic [NK-1:0][3:0][7:0]   pack_q, pack_d;
  logic [NK-1:0][3:0][7:0]   pooled_q, pooled_d;
  logic                      out_valid_q, out_valid_d;
  logic                      frame_done_q, frame_done_d;

  logic [LIW-1:0] lb_idx;
  logic           accept;
  logic           last;

  function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a : b;
  endfunction

  assign lb_idx = LIW'(col_q >> 1);
  assign accept = in_valid && (state_q == RUN) && !start;
  assign last   = (col_q == COL_LAST) && (row_q == ROW_LAST);

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    lane_d       = lane_q;
    hold_d       = hold_q;
    lb_d         = lb_q;
    pack_d       = pack_q;
    pooled_d     = pooled_q;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;

    if (start) begin
      // start also aborts a running frame; the line buffer is rewritten before any read
      state_d = RUN;
      col_d   = '0;
      row_d   = '0;
      lane_d  = '0;
      hold_d  = '0;
      pack_d  = '0;
    end else if (accept) begin
      for (int k = 0; k < NK; k++) begin
        if (!col_q[0]) begin
          hold_d[k] = conv_in[k];
        end else if (!row_q[0]) begin
          lb_d[k][lb_idx] = max8(hold_q[k], conv_in[k]);
        end else begin
          pack_d[k][lane_q] = max8(max8(lb_q[k][lb_idx], hold_q[k]), conv_in[k]);
        end
      end

      if (col_q[0] && row_q[0]) begin
        lane_d = lane_q + 2'd1;
        if (lane_q == 2'd3) begin
          pooled_d     = pack_d;
          out_valid_d  = 1'b1;
          frame_done_d = last;
        end
      end

      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q == ROW_LAST) begin
          row_d   = '0;
          state_d = IDLE;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      lane_q       <= '0;
      hold_q       <= '0;
      lb_q         <= '0;
      pack_q       <= '0;
      pooled_q     <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      lane_q       <= lane_d;
      hold_q       <= hold_d;
      lb_q         <= lb_d;
      pack_q       <= pack_d;
      pooled_q     <= pooled_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
  assign pooled_out = pooled_q;
  assign busy       = (state_q == RUN);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_max_pool_packer.sv
// Bench for max_pool_packer: frames are built as whole images and the expected
// packed words are derived from 2x2 window maxima over each image.
module tb_max_pool_packer;

  localparam int NK     = 2;
  localparam int MAP_W  = 8;
  localparam int MAP_H  = 8;
  localparam int NS     = MAP_W * MAP_H;
  localparam int NWIN   = (MAP_W / 2) * (MAP_H / 2);
  localparam int NWORDS = NWIN / 4;
  localparam int WW     = NK * 32;
  localparam int W      = WW + 1;
  localparam int CIW    = NK * 8;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    start = 1'b0;
  logic                    in_valid = 1'b0;
  logic [NK-1:0][7:0]      conv_in = '0;
  logic                    out_valid;
  logic [NK-1:0][3:0][7:0] pooled_out;
  logic                    frame_done;
  logic                    busy;
  logic                    dbg_state;

  max_pool_packer #(.NK(NK), .MAP_W(MAP_W), .MAP_H(MAP_H)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .conv_in    (conv_in),
    .out_valid  (out_valid),
    .pooled_out (pooled_out),
    .frame_done (frame_done),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int ov_count = 0;
  int fd_count = 0;
  logic [W-1:0]            exp_q[$];
  logic [WW-1:0]           got_q[$];
  logic [NK-1:0][3:0][7:0] last_word = '0;
  logic [7:0]              img [NK][MAP_H][MAP_W];

  // ---------------- reference model ----------------
  function automatic int word_done_idx(input int j);
    int wi, wr, wc;
    wi = 4 * j + 3;
    wr = wi / (MAP_W / 2);
    wc = wi % (MAP_W / 2);
    return (2 * wr + 1) * MAP_W + 2 * wc + 1;
  endfunction

  function automatic logic completes_word(input int idx);
    for (int j = 0; j < NWORDS; j++)
      if (word_done_idx(j) == idx) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_push(input int n);
    logic [NK-1:0][3:0][7:0] w;
    logic                    fd;
    logic [7:0]              m;
    int                      wi, wr, wc;
    for (int j = 0; j < NWORDS; j++) begin
      if (word_done_idx(j) < n) begin
        w = '0;
        for (int l = 0; l < 4; l++) begin
          wi = 4 * j + l;
          wr = wi / (MAP_W / 2);
          wc = wi % (MAP_W / 2);
          for (int k = 0; k < NK; k++) begin
            m = 8'd0;
            for (int dr = 0; dr < 2; dr++)
              for (int dc = 0; dc < 2; dc++)
                if (img[k][2*wr+dr][2*wc+dc] > m) m = img[k][2*wr+dr][2*wc+dc];
            w[k][l] = m;
          end
        end
        fd = (n == NS) && (j == NWORDS - 1);
        exp_q.push_back({fd, w});
      end
    end
  endtask

  task automatic gen_ramp();
    for (int r = 0; r < MAP_H; r++)
      for (int c = 0; c < MAP_W; c++) begin
        img[0][r][c] = 8'(r * MAP_W + c);
        img[1][r][c] = 8'(255 - (r * MAP_W + c));
      end
  endtask

  task automatic gen_random();
    for (int k = 0; k < NK; k++)
      for (int r = 0; r < MAP_H; r++)
        for (int c = 0; c < MAP_W; c++)
          img[k][r][c] = 8'($urandom_range(0, 255));
  endtask

  // every window gets hi at one position (rotating per window/kernel), lo elsewhere
  task automatic gen_windows(input logic [7:0] hi, input logic [7:0] lo);
    int wr, wc, pos;
    for (int k = 0; k < NK; k++)
      for (int wi = 0; wi < NWIN; wi++) begin
        wr  = wi / (MAP_W / 2);
        wc  = wi % (MAP_W / 2);
        pos = (wi + wi / 4 + k) % 4;
        for (int p = 0; p < 4; p++)
          img[k][2*wr + p/2][2*wc + p%2] = (p == pos) ? hi : lo;
      end
  endtask

  // ---------------- clock step + scoreboard ----------------
  task automatic tick();
    logic [W-1:0] e;
    @(posedge clk);
    #1;
    if (!rst) begin
      last_word = '0;
    end else if (out_valid) begin
      ov_count++;
      if (frame_done) fd_count++;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: out_valid=1 word=%h, expected no word", pooled_out);
      end else begin
        e = exp_q.pop_front();
        if ({frame_done, pooled_out} !== e) begin
          n_fail++;
          $display("FAIL sb_word: got fd=%b word=%h, expected fd=%b word=%h",
                   frame_done, pooled_out, e[W-1], e[WW-1:0]);
        end
      end
      got_q.push_back(pooled_out);
      last_word = pooled_out;
    end else begin
      n_tests++;
      if (frame_done !== 1'b0 || pooled_out !== last_word) begin
        n_fail++;
        $display("FAIL hold_stable: fd=%b word=%h, expected fd=0 word=%h",
                 frame_done, pooled_out, last_word);
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic do_start(input logic with_valid);
    start    = 1'b1;
    in_valid = with_valid;
    conv_in  = {NK{8'hFF}};
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start_busy: busy=%b, expected 1", busy);
    end
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL start_ov: out_valid=%b, expected 0", out_valid);
    end
  endtask

  task automatic drive_frame(input int n, input int gap_mode);
    int   r, c, gaps;
    logic exp_ov;
    for (int idx = 0; idx < n; idx++) begin
      r = idx / MAP_W;
      c = idx % MAP_W;
      gaps = (idx == 0) ? 0 : (gap_mode == 1) ? 1 : (gap_mode == 2) ? $urandom_range(0, 2) : 0;
      for (int g = 0; g < gaps; g++) begin
        in_valid = 1'b0;
        conv_in  = CIW'($urandom);
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL gap_ov: out_valid=%b at idle cycle before sample %0d, expected 0", out_valid, idx);
        end
      end
      in_valid = 1'b1;
      for (int k = 0; k < NK; k++) conv_in[k] = img[k][r][c];
      tick();
      in_valid = 1'b0;
      exp_ov = completes_word(idx);
      n_tests++;
      if (out_valid !== exp_ov) begin
        n_fail++;
        $display("FAIL ov_timing: sample %0d out_valid=%b, expected %b", idx, out_valid, exp_ov);
      end
      n_tests++;
      if (frame_done !== (exp_ov && idx == NS - 1 && n == NS)) begin
        n_fail++;
        $display("FAIL fd_timing: sample %0d frame_done=%b, expected %b", idx, frame_done,
                 exp_ov && idx == NS - 1 && n == NS);
      end
    end
  endtask

  task automatic idle_valid(input int cycles, input string name);
    for (int i = 0; i < cycles; i++) begin
      in_valid = 1'b1;
      conv_in  = CIW'($urandom);
      tick();
      n_tests++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL %s: out_valid=%b busy=%b, expected 0 0", name, out_valid, busy);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic check_frame_end(input int ov0, input int fd0, input string name);
    n_tests++;
    if (ov_count - ov0 != NWORDS) begin
      n_fail++;
      $display("FAIL %s_count: %0d words, expected %0d", name, ov_count - ov0, NWORDS);
    end
    n_tests++;
    if (fd_count - fd0 != 1) begin
      n_fail++;
      $display("FAIL %s_fd: %0d frame_done pulses, expected 1", name, fd_count - fd0);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_busy: busy=%b after last sample, expected 0", name, busy);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_pending: %0d words, expected 0", name, exp_q.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    #3;
    n_tests++;
    if (out_valid !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b0 ||
        pooled_out !== '0 || dbg_state !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_vals: ov=%b fd=%b busy=%b st=%b word=%h, expected all 0",
               out_valid, frame_done, busy, dbg_state, pooled_out);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_ramp(input int gap_mode, input string name);
    int ov0, fd0;
    logic [NK-1:0][3:0][7:0] gw;
    gen_ramp();
    model_push(NS);
    got_q.delete();
    ov0 = ov_count;
    fd0 = fd_count;
    do_start(1'b0);
    drive_frame(NS, gap_mode);
    check_frame_end(ov0, fd0, name);
    n_tests++;
    if (got_q.size() < 2) begin
      n_fail++;
      $display("FAIL %s_words: %0d captured, expected at least 2", name, got_q.size());
    end else begin
      gw = got_q[0];
      if (gw[0] !== {8'd15, 8'd13, 8'd11, 8'd9} || gw[1] !== {8'd249, 8'd251, 8'd253, 8'd255}) begin
        n_fail++;
        $display("FAIL %s_word0: k0=%h k1=%h, expected 0f0d0b09 f9fbfdff", name, gw[0], gw[1]);
      end
      n_tests++;
      gw = got_q[1];
      if (gw[0] !== {8'd31, 8'd29, 8'd27, 8'd25}) begin
        n_fail++;
        $display("FAIL %s_word1: k0=%h, expected 1f1d1b19", name, gw[0]);
      end
    end
  endtask

  task automatic test_window_pos(input logic [7:0] hi, input logic [7:0] lo, input string name);
    int ov0, fd0;
    logic [NK-1:0][3:0][7:0] gw;
    gen_windows(hi, lo);
    model_push(NS);
    got_q.delete();
    ov0 = ov_count;
    fd0 = fd_count;
    do_start(1'b0);
    drive_frame(NS, 0);
    check_frame_end(ov0, fd0, name);
    for (int j = 0; j < got_q.size(); j++) begin
      gw = got_q[j];
      for (int k = 0; k < NK; k++)
        for (int l = 0; l < 4; l++) begin
          n_tests++;
          if (gw[k][l] !== hi) begin
            n_fail++;
            $display("FAIL %s_lane: word %0d k%0d lane %0d = %h, expected %h", name, j, k, l, gw[k][l], hi);
          end
        end
    end
  endtask

  task automatic test_abort();
    int ov0, fd0;
    gen_random();
    model_push(13);
    do_start(1'b0);
    drive_frame(13, 2);
    gen_random();
    model_push(20);
    do_start(1'b0);
    drive_frame(20, 0);
    gen_ramp();
    model_push(NS);
    ov0 = ov_count;
    fd0 = fd_count;
    do_start(1'b0);
    drive_frame(NS, 0);
    check_frame_end(ov0, fd0, "abort");
  endtask

  task automatic test_idle();
    int ov0, fd0;
    idle_valid(5, "idle_before");
    gen_ramp();
    model_push(NS);
    ov0 = ov_count;
    fd0 = fd_count;
    do_start(1'b1);
    drive_frame(NS, 0);
    check_frame_end(ov0, fd0, "start_valid");
    idle_valid(6, "idle_after");
    gen_random();
    model_push(NS);
    ov0 = ov_count;
    fd0 = fd_count;
    do_start(1'b0);
    drive_frame(NS, 0);
    check_frame_end(ov0, fd0, "idle_next");
  endtask

  task automatic test_random();
    int ov0, fd0;
    for (int f = 0; f < 2; f++) begin
      gen_random();
      model_push(NS);
      ov0 = ov_count;
      fd0 = fd_count;
      do_start(1'b0);
      drive_frame(NS, 2);
      check_frame_end(ov0, fd0, "random");
    end
  endtask

  task automatic test_reset_mid();
    int ov0, fd0;
    gen_random();
    model_push(30);
    do_start(1'b0);
    drive_frame(30, 2);
    rst = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b0 ||
        pooled_out !== '0 || dbg_state !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: ov=%b fd=%b busy=%b st=%b word=%h, expected all 0",
               out_valid, frame_done, busy, dbg_state, pooled_out);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_mid_pending: %0d words, expected 0", exp_q.size());
    end
    exp_q.delete();
    last_word = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle_valid(5, "reset_idle");
    gen_ramp();
    model_push(NS);
    ov0 = ov_count;
    fd0 = fd_count;
    do_start(1'b0);
    drive_frame(NS, 0);
    check_frame_end(ov0, fd0, "reset_next");
  endtask

  initial begin
    test_reset();
    test_ramp(0, "ramp");
    test_ramp(1, "toggle");
    test_window_pos(8'd200, 8'd0, "winpos");
    test_window_pos(8'h80, 8'h7F, "unsigned");
    test_abort();
    test_idle();
    test_random();
    test_reset_mid();
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/max_pool_packer.md
# max_pool_packer

Streaming 2x2 max-pooling stage directly downstream of the per-kernel convolution neurons. Each accepted cycle takes one 8-bit convolution result per kernel, in raster order over a MAP_W x MAP_H feature map. It pools non-overlapping 2x2 windows with a half-row line buffer. Each group of four pooled values per kernel is packed into a 4x8-bit word, which feeds the fully-connected weight stage.

## Interface

- NK, 2: number of kernels, i.e. parallel feature maps.
- MAP_W, 8: feature-map width in samples; even, at least 2.
- MAP_H, 8: feature-map height in rows; even, at least 2. (MAP_W/2)*(MAP_H/2) must be a multiple of 4.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; clears all counters and packing state and arms a new frame.
- in_valid  in  1  conv_in carries a valid sample this cycle.
- conv_in  in  [NK-1:0][7:0]  one convolution result per kernel, unsigned.
- out_valid  out  1  one-cycle pulse; pooled_out holds a new packed word.
- pooled_out  out  [NK-1:0][3:0][7:0]  packed pooled values per kernel. Lane 0 is the oldest.
- frame_done  out  1  one-cycle pulse coincident with the last out_valid of a frame.
- busy  out  1  high from start until the frame's last sample is accepted.

## Operation

- State machine: IDLE -> (start) -> RUN -> (last sample accepted) -> IDLE.
  - In IDLE, in_valid is ignored.
- Counters, all cleared by start:
  - col, 0..MAP_W-1; wraps to 0 and increments row.
  - row, 0..MAP_H-1.
  - lane, 0..3; counts pooled values per word.
- Per kernel k, on each accepted sample x (in_valid, RUN, no start this cycle):
  - Even col: hold[k] <= x.
  - Odd col, even row: lb[k][col/2] <= max(hold[k], x). The line buffer is MAP_W/2 entries of 8 bits.
  - Odd col, odd row: p = max(lb[k][col/2], hold[k], x). Write p to pack[k][lane].
  - lane increments only on odd col of odd row, shared across kernels, and wraps 3 -> 0.
  - When lane was 3, the complete word moves into pooled_out and out_valid is set.
- All comparisons are unsigned 8-bit. No arithmetic widening; the output equals one input value.
- Last sample: row = MAP_H-1 and col = MAP_W-1.
  - busy falls the following cycle.
  - That sample's out_valid also carries frame_done.
- start while busy aborts the frame.
  - Counters reset and partial pack/hold contents are discarded. lb need not be cleared; it is overwritten before use.
  - busy stays high.
- start together with in_valid: start wins and the sample is dropped.
- in_valid low: no counters move, and gaps of any length are allowed.

## Timing

- Reset values: out_valid 0, frame_done 0, busy 0, pooled_out all 0. Internal counters and state are also 0, with state IDLE.
- busy rises the cycle after start.
- A sample is accepted on the first edge with busy=1 and in_valid=1.
- Latency: out_valid is registered and pulses the cycle after the edge that accepts the completing sample.
- pooled_out is stable until the next out_valid; there is no back-pressure.
- Throughput: 1 sample per cycle sustained, giving one word per 8 accepted odd-row samples of the map.
- Reset asserted mid-frame returns all state to reset values immediately (asynchronous). A new start is required afterwards.

## Test plan

- Ramp, MAP_W=MAP_H=8, NK=2. start, then 64 back-to-back samples; kernel 0 = row*8+col, kernel 1 = 255-(row*8+col).
  - 4 out_valid pulses; frame_done on the 4th; busy low after the last.
  - Kernel 0 word 0 lanes 0..3 = 9,11,13,15; word 1 = 25,27,29,31.
  - Kernel 1 word 0 = 255,253,251,249.
- Same stream with in_valid toggled every other cycle: identical words and order. Each out_valid comes 1 cycle after its completing sample.
- Max in each of the 4 window positions: 200 placed in turn at top-left, top-right, bottom-left, bottom-right; all others 0.
  - Each yields 200 in the corresponding lane.
  - Unsigned check: 0x80 vs 0x7F gives 0x80.
- start mid-frame after 20 samples, then a full 64-sample frame: exactly 4 out_valid. Words match the ramp case with no stale values.
- in_valid while IDLE (before start and after frame end): no counter movement and no out_valid.
- Also in this scenario: start together with in_valid drops that sample.
- rst low mid-frame: outputs 0 immediately; busy 0; subsequent in_valid ignored until start.
